seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
- Holds a packed hex value and steps through the digits one at a time.
- Presents the current 4-bit nibble to the downstream hex-to-cathode decoder and drives the matching anode.
- Inserts a blanking gap between digits against ghosting and updates the displayed value only at frame boundaries, so a digit never tears mid-frame.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_slot_timer.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 110 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg7_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

  localparam int MAX_DIGITS = 16;

  // All-anodes-off word for an active-low display; invert for active-high.
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

  function automatic logic anode_on(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-slot cycle counter: strobes the last blank cycle and the last slot cycle.
module seg7_slot_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start_o,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign slot_start_o = (cnt_q == '0);
  assign blank_done_o = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  assign slot_done_o  = (cnt_q == CNT_W'(SLOT_CYCLES - 1));

  always_comb begin
    cnt_d = slot_done_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-slot blanking, frame-aligned
// value updates, digit enables and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int SLOT_CYCLES      = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int IDX_W = idx_w(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam logic [NUM_DIGITS-1:0] OFF =
    ANODE_ACTIVE_LOW ? ANODES_OFF[NUM_DIGITS-1:0] : ~ANODES_OFF[NUM_DIGITS-1:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, didx_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
  logic [3:0]              digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic                    tick_q, tick_d;
  logic                    slot_start, blank_done, slot_done, frame_start;
  logic                    lz_zero, suppress;

  seg7_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_start_o(slot_start),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

  // A load coinciding with the frame start bypasses straight into the display.
  assign frame_start = (state_q == BLANK) && (idx_q == '0) && slot_start;
  assign shadow_d    = load ? value : shadow_q;
  assign disp_d      = frame_start ? shadow_d : disp_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      BLANK: if (blank_done) state_d = SHOW;
      SHOW: begin
        if (slot_done) begin
          state_d = BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  // lz_zero: the current nibble and every more significant one are zero.
  always_comb begin
    lz_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'h0) lz_zero = 1'b0;
    end
  end

  always_comb begin
    suppress = !digit_en[idx_q] || (lz_blank && (idx_q != '0) && lz_zero);
    anodes_d = OFF;
    if (state_q == SHOW && !suppress) anodes_d[idx_q] = anode_on(1'b1, ANODE_ACTIVE_LOW);
    digit_d  = disp_d[{idx_q, 2'b00} +: 4];
    tick_d   = frame_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BLANK;
      idx_q    <= '0;
      didx_q   <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      digit_q  <= '0;
      anodes_q <= OFF;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      didx_q   <= idx_q;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      digit_q  <= digit_d;
      anodes_q <= anodes_d;
      tick_q   <= tick_d;
    end
  end

  assign digit      = digit_q;
  assign anodes     = anodes_q;
  assign digit_idx  = didx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: per-cycle expected outputs are queued from a
// slot-arithmetic reference and compared after each clock edge.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] digit;
    logic [3:0] an;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  int          c = 0;
  int          last_tick = -1;
  logic [15:0] shadow_m = 16'h0;
  logic [15:0] disp_m = 16'h0;

  seg7_scan_ctrl #(
    .NUM_DIGITS      (ND),
    .SLOT_CYCLES     (SC),
    .BLANK_CYCLES    (BC),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .digit     (digit),
    .anodes    (anodes),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: predict outputs from the inputs now driven, clock, compare.
  task automatic step();
    int   p;
    int   ix;
    exp_t e;
    p  = c % FRAME;
    ix = p / SC;
    if (p == 0) disp_m = load ? value : shadow_m;
    if (load) shadow_m = value;
    e.tick  = (p == 0);
    e.idx   = ix[1:0];
    e.digit = disp_m[ix*4 +: 4];
    e.an    = 4'hF;
    if ((p % SC) >= BC && digit_en[ix] &&
        !(lz_blank && ix != 0 && (disp_m >> (4*ix)) == 16'h0))
      e.an[ix] = 1'b0;
    q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    e = q.pop_front();
    chk("frame_tick", 32'(frame_tick), 32'(e.tick));
    chk("digit_idx", 32'(digit_idx), 32'(e.idx));
    chk("digit", 32'(digit), 32'(e.digit));
    chk("anodes", 32'(anodes), 32'(e.an));
    if (frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_period", 32'(c - last_tick), 32'(FRAME));
      last_tick = c;
    end
    $display("cyc %0d: idx=%0d digit=%h anodes=%b tick=%b", c, digit_idx, digit, anodes, frame_tick);
    c++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #12;
    chk("rst_anodes", 32'(anodes), 32'hF);
    chk("rst_digit", 32'(digit), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First frame displays the reset value; 1234 appears from the second frame.
    step();
    value = 16'h1234; load = 1'b1; step();
    run(70);

    // Back-to-back loads mid-frame, then a value change with load low.
    value = 16'h1111; load = 1'b1; step();
    value = 16'hABCD; load = 1'b1; step();
    value = 16'hFFFF;
    run(60);

    // Leading-zero suppression on and off.
    value = 16'h00F0; load = 1'b1; lz_blank = 1'b1; step();
    run(40);
    lz_blank = 1'b0;
    run(32);

    // Per-digit enables.
    digit_en = 4'b0101; value = 16'h5555; load = 1'b1; step();
    run(70);
    digit_en = 4'hF;

    // Load exactly on the frame-start cycle.
    while (c % FRAME != 0) step();
    value = 16'h9876; load = 1'b1; step();
    run(10);

    // Reset during SHOW of slot 2.
    while (c % FRAME != 2*SC + 3) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_anodes", 32'(anodes), 32'hF);
    chk("async_rst_idx", 32'(digit_idx), 32'h0);
    chk("async_rst_tick", 32'(frame_tick), 32'h0);
    chk("async_rst_digit", 32'(digit), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c = 0; shadow_m = 16'h0; disp_m = 16'h0; last_tick = -1;
    run(40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
